// File: rtl/mat_vec_mult_pkg.sv
// Shared types and helpers for the matrix-vector multiplier.
//   state_t      : controller states (IDLE, MAC, DONE)
//   acc_width()  : accumulator width for a given element width and dimension
//   round_const(): round-half-up constant added before the fractional shift
package mat_vec_mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Full-precision product plus headroom for summing dim products.
   function automatic int unsigned acc_width(input int unsigned width, input int unsigned dim);
      return 2 * width + $clog2(dim);
   endfunction

   // 2^(frac-1), or zero when there are no fractional bits.
   function automatic logic [127:0] round_const(input int unsigned frac);
      logic [127:0] r;
      r = '0;
      if (frac > 0) r = 128'd1 << (frac - 1);
      return r;
   endfunction

endpackage

// File: rtl/mat_vec_mult_mac_lane.sv
// One multiply-accumulate lane.
//   clk_in, rst_n_in : clock, async active-low reset
//   clr              : restart the sum (with acc_en, load the product)
//   acc_en           : add op_a*op_b into the accumulator this cycle
//   op_a, op_b       : signed WIDTH-bit operands
//   acc              : ACC_W-bit signed accumulator
module mac_lane #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned ACC_W = 66
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             clr,
   input  logic             acc_en,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic [ACC_W-1:0] acc
);

   logic [2*WIDTH-1:0] prod_c;
   logic [ACC_W-1:0]   prod_ext_c;

   // Sign-extend both operands so the low 2*WIDTH bits are the exact signed product.
   assign prod_c = $signed({{WIDTH{op_a[WIDTH-1]}}, op_a}) *
                   $signed({{WIDTH{op_b[WIDTH-1]}}, op_b});
   assign prod_ext_c = {{(ACC_W-2*WIDTH){prod_c[2*WIDTH-1]}}, prod_c};

   // Accumulator register
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         acc <= '0;
      end else if (acc_en) begin
         acc <= (clr ? '0 : acc) + prod_ext_c;
      end else if (clr) begin
         acc <= '0;
      end
   end

endmodule

// File: rtl/mat_vec_mult.sv
// Fixed-point matrix-vector multiplier: vec_out = mat_in * vec_in.
// LANES rows are accumulated in parallel; each lane walks rows
// l, l+LANES, ... one column per cycle.
//   clk_in, rst_n_in      : clock, async active-low reset
//   valid_in / ready_out  : operand handshake (mat_in[row][col], vec_in[col])
//   valid_out / ready_in  : result handshake (vec_out[row], ovf_out)
// Build option: define MAT_VEC_MULT_SAT_EN to saturate results and report
// clamping on ovf_out; otherwise results wrap and ovf_out is 0.
module mat_vec_mult
   import mat_vec_mult_pkg::*;
#(
   parameter int unsigned DIM   = 4,
   parameter int unsigned WIDTH = 32,
   parameter int unsigned FRAC  = 16,
   parameter int unsigned LANES = 4
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             valid_in,
   output logic             ready_out,
   input  logic [WIDTH-1:0] mat_in [DIM][DIM],
   input  logic [WIDTH-1:0] vec_in [DIM],
   output logic             valid_out,
   input  logic             ready_in,
   output logic [WIDTH-1:0] vec_out [DIM],
   output logic             ovf_out
);

   localparam int unsigned ACC_W  = acc_width(WIDTH, DIM);
   localparam int unsigned GROUPS = DIM / LANES;
   localparam int unsigned COL_W  = $clog2(DIM);
   localparam int unsigned GRP_W  = $clog2(GROUPS + 1);
   localparam logic [ACC_W-1:0] RND = ACC_W'(round_const(FRAC));

   // Parameter sanity
   if ((LANES == 0) || (DIM % LANES != 0)) begin : g_bad_lanes
      $error("mat_vec_mult: LANES must divide DIM");
   end
   if ((DIM < 2) || (DIM > 16)) begin : g_bad_dim
      $error("mat_vec_mult: DIM must be 2..16");
   end
   if (FRAC >= WIDTH) begin : g_bad_frac
      $error("mat_vec_mult: FRAC must be below WIDTH");
   end

   state_t           state_q, state_d;
   logic [WIDTH-1:0] mat_q [DIM][DIM];
   logic [WIDTH-1:0] vec_q [DIM];
   logic [COL_W-1:0] col_q;
   logic [GRP_W-1:0] grp_q;

   logic             accept_c, fin_c, mac_en_c, latch_c;
   logic [WIDTH-1:0] lane_a_c [LANES];
   logic [WIDTH-1:0] lane_b_c;
   logic [ACC_W-1:0] lane_acc [LANES];
   logic [ACC_W-1:0] res_full_c [LANES];
   logic [WIDTH-1:0] lane_res_c [LANES];

   // State register
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) state_q <= IDLE;
      else           state_q <= state_d;
   end

   // Next state and operand-side ready
   always_comb begin
      state_d   = state_q;
      ready_out = 1'b0;
      case (state_q)
         IDLE: begin
            ready_out = 1'b1;
            if (valid_in) state_d = MAC;
         end
         MAC: begin
            if (grp_q == GRP_W'(GROUPS)) state_d = DONE;
         end
         DONE: begin
            if (ready_in) begin
               ready_out = 1'b1;
               state_d   = valid_in ? MAC : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign accept_c = valid_in & ready_out;
   // grp_q == GROUPS marks the extra cycle that stores the last row of each lane.
   assign fin_c    = (state_q == MAC) && (grp_q == GRP_W'(GROUPS));
   assign mac_en_c = (state_q == MAC) && !fin_c;
   // At column 0 of a new group the lanes hold the finished sums of the previous group.
   assign latch_c  = (state_q == MAC) && (col_q == '0) && (grp_q != '0);

   // Operand select: lane l in group g works on row l + LANES*g
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         lane_a_c[l] = '0;
         for (int g = 0; g < GROUPS; g++) begin
            if (grp_q == GRP_W'(g)) lane_a_c[l] = mat_q[l + LANES*g][col_q];
         end
      end
      lane_b_c = vec_q[col_q];
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      mac_lane #(
         .WIDTH (WIDTH),
         .ACC_W (ACC_W)
      ) u_lane (
         .clk_in   (clk_in),
         .rst_n_in (rst_n_in),
         .clr      (mac_en_c && (col_q == '0)),
         .acc_en   (mac_en_c),
         .op_a     (lane_a_c[l]),
         .op_b     (lane_b_c),
         .acc      (lane_acc[l])
      );
   end

   // Round half up, then drop the fractional bits
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         res_full_c[l] = $signed(lane_acc[l] + RND) >>> FRAC;
      end
   end

`ifdef MAT_VEC_MULT_SAT_EN
   localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic [LANES-1:0] clip_c;

   // Clamp when the bits above the WIDTH-1 sign position are not all equal
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         clip_c[l]     = 1'b0;
         lane_res_c[l] = res_full_c[l][WIDTH-1:0];
         if (!((&res_full_c[l][ACC_W-1:WIDTH-1]) || !(|res_full_c[l][ACC_W-1:WIDTH-1]))) begin
            clip_c[l]     = 1'b1;
            lane_res_c[l] = res_full_c[l][ACC_W-1] ? SAT_MIN : SAT_MAX;
         end
      end
   end

   // Sticky overflow for the result being assembled
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         ovf_out <= 1'b0;
      end else if (accept_c) begin
         ovf_out <= 1'b0;
      end else if (latch_c) begin
         ovf_out <= ovf_out | (|clip_c);
      end
   end
`else
   logic unused_hi_c;

   // Two's-complement wrap to WIDTH bits
   always_comb begin
      unused_hi_c = 1'b0;
      for (int l = 0; l < LANES; l++) begin
         lane_res_c[l] = res_full_c[l][WIDTH-1:0];
         unused_hi_c   = unused_hi_c ^ (^res_full_c[l][ACC_W-1:WIDTH]);
      end
   end

   assign ovf_out = 1'b0;
`endif

   // Operand capture, column/group counters, result registers
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) mat_q[r][c] <= '0;
            vec_q[r]   <= '0;
            vec_out[r] <= '0;
         end
         col_q     <= '0;
         grp_q     <= '0;
         valid_out <= 1'b0;
      end else begin
         if (accept_c) begin
            mat_q <= mat_in;
            vec_q <= vec_in;
            col_q <= '0;
            grp_q <= '0;
         end else if (mac_en_c) begin
            if (col_q == COL_W'(DIM - 1)) begin
               col_q <= '0;
               grp_q <= grp_q + GRP_W'(1);
            end else begin
               col_q <= col_q + COL_W'(1);
            end
         end

         if (fin_c) valid_out <= 1'b1;
         else if ((state_q == DONE) && ready_in) valid_out <= 1'b0;

         for (int r = 0; r < DIM; r++) begin
            if (latch_c && (grp_q == GRP_W'(r / LANES + 1))) vec_out[r] <= lane_res_c[r % LANES];
         end
      end
   end

endmodule

// File: tb/tb_mat_vec_mult.sv
// Scoreboard bench for mat_vec_mult (DIM=4, WIDTH=32, FRAC=16).
// Main instance uses LANES=4; two extra instances (LANES=2, LANES=1) check latency.
module tb_mat_vec_mult;

   localparam int unsigned DIM   = 4;
   localparam int unsigned WIDTH = 32;
   localparam int unsigned FRAC  = 16;
   localparam int LAT_MAIN = 5;
   localparam logic [WIDTH-1:0] ONE = 32'h0001_0000;

   typedef struct packed {
      logic [DIM-1:0][WIDTH-1:0] v;
      logic                      ovf;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             valid_in = 1'b0;
   logic             ready_in = 1'b1;
   logic             ready_out, valid_out, ovf_out;
   logic [WIDTH-1:0] mat [DIM][DIM];
   logic [WIDTH-1:0] vec [DIM];
   logic [WIDTH-1:0] vec_out [DIM];

   logic             vx = 1'b0;
   logic             one_c = 1'b1;
   logic             r2_rdy, r2_vld, r2_ovf, r1_rdy, r1_vld, r1_ovf;
   logic [WIDTH-1:0] r2_vec [DIM];
   logic [WIDTH-1:0] r1_vec [DIM];

   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   exp_t exp_q[$];
   int   acc_q[$];

   always #5 clk = ~clk;

   mat_vec_mult #(.DIM(DIM), .WIDTH(WIDTH), .FRAC(FRAC), .LANES(4)) dut (
      .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid_in), .ready_out(ready_out),
      .mat_in(mat), .vec_in(vec), .valid_out(valid_out), .ready_in(ready_in),
      .vec_out(vec_out), .ovf_out(ovf_out));

   mat_vec_mult #(.DIM(DIM), .WIDTH(WIDTH), .FRAC(FRAC), .LANES(2)) u_l2 (
      .clk_in(clk), .rst_n_in(rst_n), .valid_in(vx), .ready_out(r2_rdy),
      .mat_in(mat), .vec_in(vec), .valid_out(r2_vld), .ready_in(one_c),
      .vec_out(r2_vec), .ovf_out(r2_ovf));

   mat_vec_mult #(.DIM(DIM), .WIDTH(WIDTH), .FRAC(FRAC), .LANES(1)) u_l1 (
      .clk_in(clk), .rst_n_in(rst_n), .valid_in(vx), .ready_out(r1_rdy),
      .mat_in(mat), .vec_in(vec), .valid_out(r1_vld), .ready_in(one_c),
      .vec_out(r1_vec), .ovf_out(r1_ovf));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic exp_t mk(input logic [WIDTH-1:0] a, b, c, d, input logic o);
      exp_t e;
      e.v[0] = a; e.v[1] = b; e.v[2] = c; e.v[3] = d; e.ovf = o;
      return e;
   endfunction

   // Edge counter; records the edge number of every operand accept
   always @(posedge clk) begin
      cyc++;
      if (rst_n && valid_in && ready_out) acc_q.push_back(cyc);
   end

   // Monitor: compare each new result against the scoreboard
   bit   seen = 1'b0;
   exp_t mon_e;
   int   mon_a;
   always @(negedge clk) begin
      if (!valid_out) begin
         seen = 1'b0;
      end else begin
         if (!seen) begin
            seen = 1'b1;
            if (exp_q.size() == 0) begin
               chk("unexpected_valid_out", 64'(valid_out), 64'd0);
            end else begin
               mon_e = exp_q.pop_front();
               mon_a = (acc_q.size() != 0) ? acc_q.pop_front() : -1000;
               for (int i = 0; i < DIM; i++)
                  chk($sformatf("vec_out[%0d]", i), 64'(vec_out[i]), 64'(mon_e.v[i]));
               chk("ovf_out", 64'(ovf_out), 64'(mon_e.ovf));
               chk("latency", 64'(cyc - mon_a), 64'(LAT_MAIN));
            end
         end
         if (ready_in) seen = 1'b0;
      end
   end

   task automatic set_mat_all(input logic [WIDTH-1:0] x);
      for (int r = 0; r < DIM; r++)
         for (int c = 0; c < DIM; c++) mat[r][c] = x;
   endtask

   task automatic set_identity();
      for (int r = 0; r < DIM; r++)
         for (int c = 0; c < DIM; c++) mat[r][c] = (r == c) ? ONE : '0;
   endtask

   task automatic set_vec(input logic [WIDTH-1:0] a, b, c, d);
      vec[0] = a; vec[1] = b; vec[2] = c; vec[3] = d;
   endtask

   // Present operands until accepted; afterwards scramble the inputs
   task automatic issue(input exp_t e, input bit push);
      int n;
      n = 0;
      valid_in = 1'b1;
      if (push) exp_q.push_back(e);
      #1;
      while (!ready_out && n < 100) begin
         @(posedge clk); #1; n++;
      end
      if (!ready_out) chk("accept_timeout", 64'(ready_out), 64'd1);
      @(posedge clk); #1;
      valid_in = 1'b0;
      mat[0][0] = 32'hDEAD_BEEF;
      set_vec(32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk); n++;
      end
      if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      @(posedge clk); #1;
   endtask

   logic [WIDTH-1:0] snap [DIM];
   logic             snap_ovf;
   bit               stable, vseen;
   int               lat2, lat1, n;

   initial begin
      set_mat_all('0);
      set_vec('0, '0, '0, '0);
      #2 rst_n = 1'b0;
      #10;
      chk("rst_valid_out", 64'(valid_out), 64'd0);
      chk("rst_ovf_out", 64'(ovf_out), 64'd0);
      chk("rst_ready_out", 64'(ready_out), 64'd1);
      for (int i = 0; i < DIM; i++) chk($sformatf("rst_vec_out[%0d]", i), 64'(vec_out[i]), 64'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_release", 64'(ready_out), 64'd1);

      // Identity matrix
      set_identity();
      set_vec(ONE, 32'hFFFE_0000, 32'h0003_8000, '0);
      issue(mk(ONE, 32'hFFFE_0000, 32'h0003_8000, '0, 1'b0), 1'b1);
      wait_drain();

      // Mixed matrix: rows give -3.0, -5.5, 0.5, 0
      set_mat_all('0);
      mat[0][0] = ONE; mat[0][1] = 32'h0002_0000;
      mat[1][1] = ONE; mat[1][2] = 32'hFFFF_0000;
      mat[2][0] = 32'h0000_8000; mat[2][3] = 32'h0002_0000;
      mat[3][3] = 32'hFFFF_0000;
      set_vec(ONE, 32'hFFFE_0000, 32'h0003_8000, '0);
      issue(mk(32'hFFFD_0000, 32'hFFFA_8000, 32'h0000_8000, '0, 1'b0), 1'b1);
      wait_drain();

      // Rounding: +half rounds up, -half rounds to zero, 1.5 lsb rounds to 2
      set_mat_all('0);
      mat[0][0] = 32'h0000_0001; mat[1][1] = 32'hFFFF_FFFF;
      mat[2][2] = 32'h0000_0001; mat[3][3] = ONE;
      set_vec(32'h0000_8000, 32'h0000_8000, 32'h0001_8000, 32'hFFFF_0000);
      issue(mk(32'h0000_0001, '0, 32'h0000_0002, 32'hFFFF_0000, 1'b0), 1'b1);
      wait_drain();

      // All 1.0 times 0.25 vector
      set_mat_all(ONE);
      set_vec(32'h4000, 32'h4000, 32'h4000, 32'h4000);
      issue(mk(ONE, ONE, ONE, ONE, 1'b0), 1'b1);
      wait_drain();

      // Backpressure hold, then back-to-back accept
      set_mat_all('0);
      mat[0][0] = ONE; mat[0][1] = 32'h0002_0000;
      mat[1][1] = ONE; mat[1][2] = 32'hFFFF_0000;
      mat[2][0] = 32'h0000_8000; mat[2][3] = 32'h0002_0000;
      mat[3][3] = 32'hFFFF_0000;
      set_vec(ONE, 32'hFFFE_0000, 32'h0003_8000, '0);
      ready_in = 1'b0;
      issue(mk(32'hFFFD_0000, 32'hFFFA_8000, 32'h0000_8000, '0, 1'b0), 1'b1);
      n = 0;
      while (!valid_out && n < 50) begin
         @(posedge clk); #1; n++;
      end
      chk("hold_valid_seen", 64'(valid_out), 64'd1);
      snap = vec_out;
      snap_ovf = ovf_out;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         stable = valid_out && (ovf_out === snap_ovf);
         for (int i = 0; i < DIM; i++) if (vec_out[i] !== snap[i]) stable = 1'b0;
         chk("hold_stable", 64'(stable), 64'd1);
         chk("hold_ready_out", 64'(ready_out), 64'd0);
      end
      set_identity();
      set_vec(32'h0000_8000, 32'hFFFF_8000, ONE, 32'h0002_0000);
      ready_in = 1'b1;
      issue(mk(32'h0000_8000, 32'hFFFF_8000, ONE, 32'h0002_0000, 1'b0), 1'b1);
      wait_drain();

      // Largest positive operands everywhere
      set_mat_all(32'h7FFF_FFFF);
      set_vec(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
`ifdef MAT_VEC_MULT_SAT_EN
      issue(mk(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1), 1'b1);
`else
      issue(mk(32'hFFFC_0000, 32'hFFFC_0000, 32'hFFFC_0000, 32'hFFFC_0000, 1'b0), 1'b1);
`endif
      wait_drain();

      // Reset in the middle of a computation
      set_identity();
      set_vec(ONE, 32'hFFFE_0000, 32'h0003_8000, '0);
      issue(mk('0, '0, '0, '0, 1'b0), 1'b0);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("midrst_valid_out", 64'(valid_out), 64'd0);
      chk("midrst_ovf_out", 64'(ovf_out), 64'd0);
      chk("midrst_ready_out", 64'(ready_out), 64'd1);
      for (int i = 0; i < DIM; i++) chk($sformatf("midrst_vec_out[%0d]", i), 64'(vec_out[i]), 64'd0);
      @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      acc_q.delete();
      @(posedge clk); #1;
      chk("midrst_ready_after_release", 64'(ready_out), 64'd1);
      vseen = 1'b0;
      repeat (30) begin
         @(posedge clk); #1;
         if (valid_out) vseen = 1'b1;
      end
      chk("midrst_no_valid_out", 64'(vseen), 64'd0);

      // Recovery after reset
      set_identity();
      set_vec(ONE, 32'hFFFE_0000, 32'h0003_8000, '0);
      issue(mk(ONE, 32'hFFFE_0000, 32'h0003_8000, '0, 1'b0), 1'b1);
      wait_drain();

      // LANES=2 and LANES=1 latency
      set_mat_all(ONE);
      set_vec(32'h4000, 32'h4000, 32'h4000, 32'h4000);
      vx = 1'b1;
      @(posedge clk); #1;
      vx = 1'b0;
      lat2 = 0; lat1 = 0;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk); #1;
         if (r2_vld && lat2 == 0) begin
            lat2 = k;
            for (int i = 0; i < DIM; i++) chk($sformatf("l2_vec_out[%0d]", i), 64'(r2_vec[i]), 64'(ONE));
            chk("l2_ovf_out", 64'(r2_ovf), 64'd0);
         end
         if (r1_vld && lat1 == 0) begin
            lat1 = k;
            for (int i = 0; i < DIM; i++) chk($sformatf("l1_vec_out[%0d]", i), 64'(r1_vec[i]), 64'(ONE));
            chk("l1_ovf_out", 64'(r1_ovf), 64'd0);
         end
      end
      chk("l2_latency", 64'(lat2), 64'd9);
      chk("l1_latency", 64'(lat1), 64'd17);

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/mat_vec_mult.md
MAT_VEC_MULT -- requirements
Module: mat_vec_mult

Interface
REQ-001 SHALL have parameter DIM, default 4, meaning matrix/vector dimension (2..16).
REQ-002 SHALL have parameter WIDTH, default 32, meaning signed fixed-point element width.
REQ-003 SHALL have parameter FRAC, default 16, meaning fractional bits per element (0..WIDTH-1).
REQ-004 SHALL have parameter LANES, default 4, meaning rows computed in parallel (must divide DIM; elaboration error otherwise).
REQ-005 SHALL have port clk_in  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst_n_in  input  1  asynchronous active-low reset.
REQ-007 SHALL have port valid_in  input  1  operands valid.
REQ-008 SHALL have port ready_out  output  1  block accepts operands.
REQ-009 SHALL have port mat_in  input  DIM x DIM x WIDTH unpacked  matrix, mat_in[row][col].
REQ-010 SHALL have port vec_in  input  DIM x WIDTH unpacked  column vector.
REQ-011 SHALL have port valid_out  output  1  result valid.
REQ-012 SHALL have port ready_in  input  1  downstream accepts result.
REQ-013 SHALL have port vec_out  output  DIM x WIDTH unpacked  result, vec_out[r] = sum_c mat[r][c]*vec[c].
REQ-014 SHALL have port ovf_out  output  1  some vec_out element saturated (qualified by valid_out).

Function
REQ-015 SHALL implement states IDLE, MAC, DONE.
REQ-016 SHALL assert ready_out in IDLE, and in DONE when ready_in=1; deasserted in MAC.
REQ-017 SHALL accept on any edge with valid_in & ready_out, registering mat_in/vec_in internally; inputs may change afterwards.
REQ-018 SHALL, in MAC, have each lane l perform one multiply-accumulate per cycle, processing rows l, l+LANES, ... over DIM columns, for DIM*DIM/LANES cycles total.
REQ-019 SHALL compute each product at full 2*WIDTH signed precision and accumulate at 2*WIDTH+clog2(DIM) bits with no intermediate rounding.
REQ-020 SHALL form each result as accumulator arithmetic-shifted right by FRAC with round-half-up (add 2^(FRAC-1) before shift when FRAC>0), then narrowed to WIDTH.
REQ-021 SHALL assert valid_out exactly DIM*DIM/LANES+1 rising edges after the accepting edge (DIM=4, LANES=4: 5; LANES=1: 17), entering DONE.
REQ-022 SHALL hold vec_out, ovf_out, valid_out stable in DONE while ready_in=0.
REQ-023 SHALL, on DONE with ready_in=1 and valid_in=0, deassert valid_out and return to IDLE next edge.
REQ-024 SHALL, on DONE with ready_in=1 and valid_in=1, consume the result and accept new operands on the same edge, entering MAC with no bubble.
REQ-025 SHALL ignore valid_in in MAC; operands are not queued.

Reset
REQ-026 SHALL, on rst_n_in=0, immediately force state IDLE, valid_out=0, ovf_out=0, vec_out all zero, accumulators zero, independent of clk_in.
REQ-027 SHALL discard any in-flight computation on reset mid-MAC or mid-DONE; no valid_out follows release.
REQ-028 SHALL assert ready_out on the first edge after rst_n_in deasserts.

Configuration
REQ-029 SHALL, with MAT_VEC_MULT_SAT_EN defined, clamp each narrowed result to [-2^(WIDTH-1), 2^(WIDTH-1)-1] and set ovf_out if any element clamped.
REQ-030 SHALL, without MAT_VEC_MULT_SAT_EN, truncate (two's-complement wrap) to WIDTH bits and tie ovf_out to 0.

Structure
REQ-031 SHALL place state enum, accumulator-width and rounding-constant functions in package mat_vec_mult_pkg.
REQ-032 SHALL use one sub-module mac_lane (clear, accumulate enable, WIDTH operands, accumulator out), instantiated LANES times via generate.

Verification
REQ-033 SHALL cover DIM=4, FRAC=16, identity matrix, vec=(1.0,-2.0,3.5,0) -> vec_out identical after 5 edges, ovf_out=0.
REQ-034 SHALL cover all mat=1.0, vec=(0.25,0.25,0.25,0.25) -> every element 1.0 (0x00010000); LANES=1 latency 17, LANES=2 latency 9.
REQ-035 SHALL cover mat all 0x7FFFFFFF, vec all 0x7FFFFFFF -> with SAT_EN all elements 0x7FFFFFFF, ovf_out=1; without, wrapped value, ovf_out=0.
REQ-036 SHALL cover ready_in=0 for 10 cycles after valid_out -> outputs stable, ready_out=0; then ready_in=1 with valid_in=1 -> back-to-back accept, next result 5 edges later.
REQ-037 SHALL cover rst_n_in pulsed low at cycle 2 of MAC -> outputs zero asynchronously, no valid_out afterwards, ready_out=1 one edge after release.
